board_mem_arbiter: RTL
======================

// Module: board_mem_arbiter
// PURPOSE
//  Shares the single board-memory port between the four direction scanners (V=0, H=1, NE=2, NW=3)
//  and the controller's stone-write path. Write requests take absolute priority; read requests
//  are granted round-robin, one memory access per clock. Read data is returned to the owning
//  scanner through a tag pipeline matched to the memory read latency.
//  Off-board coordinates are answered locally, with no memory access.
// PARAMETERS
//  N_REQ      4    number of read requesters
//  COORD_W    5    width of one X or Y coordinate
//  DATA_W     2    board cell width (00 empty, 01 white, 10 black)
//  MEM_LAT    1    cycles from mem_read asserted to mem_dout valid (1..4)
//  BOARD_SIZE 19   legal coordinates are 0..BOARD_SIZE-1
//  OFFBOARD   2'b11 value returned for off-board reads
// PORTS
//  clk       in   1               system clock
//  reset     in   1               synchronous, active-high
//  rd_req    in   N_REQ           per-scanner read request, held until granted
//  rd_x      in   N_REQ*COORD_W   packed X coordinates, requester i at [i*COORD_W +: COORD_W]
//  rd_y      in   N_REQ*COORD_W   packed Y coordinates, same packing as rd_x
//  rd_gnt    out  N_REQ           one-hot, 1-cycle pulse: request accepted this cycle
//  rd_valid  out  N_REQ           one-hot, 1-cycle pulse: rd_data belongs to requester i
//  rd_data   out  DATA_W          returned cell value, qualified by rd_valid
//  wr_req    in   1               controller write request, held until wr_ack
//  wr_x      in   COORD_W         write X coordinate
//  wr_y      in   COORD_W         write Y coordinate
//  wr_data   in   DATA_W          stone value to write
//  wr_ack    out  1               1-cycle pulse: write issued this cycle
//  mem_read  out  1               board memory read strobe
//  mem_write out  1               board memory write strobe
//  mem_x     out  COORD_W         board memory X address
//  mem_y     out  COORD_W         board memory Y address
//  mem_din   out  DATA_W          board memory write data
//  mem_dout  in   DATA_W          board memory read data, valid MEM_LAT cycles after mem_read
// BEHAVIOUR
//  - Reset (clk edge with reset=1) drives all outputs to 0, sets the RR pointer to 0 and flushes
//    the tag pipeline. Reads in flight at reset never produce rd_valid.
//  - Decision each cycle is combinational on inputs; grants and mem_* are registered (1 cycle).
//    Requester sees its rd_gnt the cycle after the decision, and must drop or change rd_req
//    the cycle after rd_gnt.
//  - Priority:
//    - wr_req=1 -> write wins: mem_write=1, mem_x/y/din = wr_x/wr_y/wr_data, wr_ack=1,
//      no rd_gnt that cycle.
//    - Else, if any rd_req: grant the first set bit at or after ptr (modulo N_REQ).
//      Then ptr <= granted index+1 (wraps N_REQ-1 -> 0).
//    - No request -> ptr unchanged, all strobes 0.
//  - Back-to-back grants are allowed every cycle. One requester alone is granted every cycle.
//  - Read issue:
//    - rd_x<BOARD_SIZE and rd_y<BOARD_SIZE -> mem_read=1 with that address.
//    - Otherwise mem_read=0 (memory untouched); the tag is still pushed with an off-board flag.
//  - Tag pipeline: MEM_LAT+1 stages of {valid, idx, offboard}. At the output stage,
//    rd_valid[idx]=1 and rd_data = offboard ? OFFBOARD : mem_dout.
//  - Latency: rd_gnt -> rd_valid is exactly MEM_LAT cycles. Returns occur in grant order.
//  - A write issued after a read that is still in flight does not affect that read's data
//    (memory order). wr_x/wr_y off-board -> wr_ack still pulses, mem_write stays 0 (write dropped).
//  - Never mem_read and mem_write in the same cycle. At most one bit set in rd_gnt, rd_valid.
//  - mem_x/y/din hold last value when idle. Idle strobes are 0.
// TESTING
//  - Reset with rd_req=4'b1111 -> all outputs 0. First grant after reset is V (rd_gnt=0001),
//    then 0010, 0100, 1000, 0001.
//  - rd_req=4'b1010, ptr=0 -> grants H then NW, alternating every cycle. NW never starved.
//  - wr_req=1 with rd_req=4'b1111 for 3 cycles -> 3 wr_ack, mem_write=1, rd_gnt=0.
//    Reads resume at the preserved ptr.
//  - Memory preloaded (3,4)=10, MEM_LAT=1: NE reads (3,4) -> rd_valid=0100, rd_data=10,
//    one cycle after its rd_gnt.
//  - V reads (19,0) -> mem_read=0, rd_valid=0001 with rd_data=11 at normal latency.
//    Write to (0,25) -> wr_ack=1, mem_write=0.
//  - Reset asserted one cycle after a grant -> no rd_valid afterwards, ptr=0.
//    Write then read same cell (5,5)=01 -> read returns 01.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// Board-memory port arbiter: stone writes win outright, scanner reads share the port round-robin,
// and read data is routed back to its scanner through a tag pipeline matched to memory latency.
module board_mem_arbiter #(
    parameter int N_REQ      = 4,
    parameter int COORD_W    = 5,
    parameter int DATA_W     = 2,
    parameter int MEM_LAT    = 1,
    parameter int BOARD_SIZE = 19,
    parameter logic [DATA_W-1:0] OFFBOARD = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           rd_req,
    input  logic [N_REQ*COORD_W-1:0]   rd_x,
    input  logic [N_REQ*COORD_W-1:0]   rd_y,
    output logic [N_REQ-1:0]           rd_gnt,
    output logic [N_REQ-1:0]           rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       wr_req,
    input  logic [COORD_W-1:0]         wr_x,
    input  logic [COORD_W-1:0]         wr_y,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ack,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [COORD_W-1:0]         mem_x,
    output logic [COORD_W-1:0]         mem_y,
    output logic [DATA_W-1:0]          mem_din,
    input  logic [DATA_W-1:0]          mem_dout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [COORD_W-1:0] BOARD_LIM = COORD_W'(BOARD_SIZE);

    // Handshake: a request is sampled every cycle it is high; the grant (or wr_ack) pulses one
    // cycle later together with the memory strobe, and rd_valid follows rd_gnt by MEM_LAT cycles.

    logic [IDX_W-1:0]   ptr;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic               rd_on_board;
    logic               wr_on_board;

    logic [MEM_LAT:0]   tag_v;
    logic [MEM_LAT:0]   tag_off;
    logic [IDX_W-1:0]   tag_idx [0:MEM_LAT];

    // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_found && rd_req[(int'(ptr) + k) % N_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        sel_x       = rd_x[int'(sel_idx)*COORD_W +: COORD_W];
        sel_y       = rd_y[int'(sel_idx)*COORD_W +: COORD_W];
        rd_on_board = (sel_x < BOARD_LIM) && (sel_y < BOARD_LIM);
        wr_on_board = (wr_x < BOARD_LIM) && (wr_y < BOARD_LIM);
        ptr_nxt     = (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + 1'b1;
    end

    // Issue stage: one memory access per clock, write before read.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            rd_gnt    <= '0;
            wr_ack    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_x     <= '0;
            mem_y     <= '0;
            mem_din   <= '0;
        end else begin
            rd_gnt    <= '0;
            wr_ack    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (wr_req) begin
                wr_ack <= 1'b1;
                if (wr_on_board) begin
                    mem_write <= 1'b1;
                    mem_x     <= wr_x;
                    mem_y     <= wr_y;
                    mem_din   <= wr_data;
                end
            end else if (sel_found) begin
                rd_gnt <= N_REQ'(1) << sel_idx;
                ptr    <= ptr_nxt;
                if (rd_on_board) begin
                    mem_read <= 1'b1;
                    mem_x    <= sel_x;
                    mem_y    <= sel_y;
                end
            end
        end
    end

    // Tag pipeline: stage 0 lines up with rd_gnt, stage MEM_LAT with mem_dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v   <= '0;
            tag_off <= '0;
            for (int s = 0; s <= MEM_LAT; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_v[0]   <= !wr_req && sel_found;
            tag_off[0] <= !rd_on_board;
            tag_idx[0] <= sel_idx;
            for (int s = 1; s <= MEM_LAT; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_off[s] <= tag_off[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    assign rd_valid = tag_v[MEM_LAT] ? (N_REQ'(1) << tag_idx[MEM_LAT]) : '0;
    assign rd_data  = !tag_v[MEM_LAT] ? '0 : (tag_off[MEM_LAT] ? OFFBOARD : mem_dout);

endmodule
